// File: rtl/list_cache_pkg.sv
// Shared constants and types for the list_cache packet path:
// default widths, word-0 field positions and the fetch arbiter state encoding.
package list_cache_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int FS_DEFAULT = 8;
  localparam int TS_DEFAULT = FS_DEFAULT - 1;

  // Word 0 of every packet: toggle "packet clock" in bit 0, requester id above it.
  localparam int TOGGLE_BIT = 0;
  localparam int ID_LSB     = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Payload words per packet: one word of every fetch is the header.
  function automatic int ts_of(input int fs);
    return fs - 1;
  endfunction

endpackage

// File: rtl/list_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the winner is the first requesting index
// strictly after the pointer, wrapping around NR.
module rr_arbiter #(
  parameter int NR  = 4,
  parameter int IDW = $clog2(NR)
) (
  input  logic [NR-1:0]  req,
  input  logic [IDW-1:0] pointer,
  output logic [NR-1:0]  winner,
  output logic [IDW-1:0] winner_idx,
  output logic           any
);

  int idx_s;

  // Scan NR slots starting one past the pointer; the first hit is kept.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx_s      = 0;
    for (int i = 1; i <= NR; i++) begin
      idx_s = (int'(pointer) + i) % NR;
      if (!any && req[idx_s]) begin
        winner[idx_s] = 1'b1;
        winner_idx    = IDW'(idx_s);
        any           = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/list_fetch_arbiter.sv
// Round-robin fetch arbiter in front of list_cache: captures one requester's
// cacheline into an FS-word packet, holds it until next_ready acknowledges it,
// and aborts with a sticky error if no acknowledge arrives within TIMEOUT cycles.
module list_fetch_arbiter
  import list_cache_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int FS      = FS_DEFAULT,
  parameter int NR      = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [NR-1:0]                     req,
  input  logic [NR*(FS-1)*DW-1:0]           req_data,
  output logic [NR-1:0]                     gnt,
  output logic [FS*DW-1:0]                  PKT,
  output logic                              pkt_valid,
  input  logic                              pkt_ack,
  output logic                              busy,
  output logic                              err,
  output logic [$clog2(NR)-1:0]             grant_id
);

  localparam int TS  = ts_of(FS);
  localparam int IDW = $clog2(NR);
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state_r;
  logic [FS*DW-1:0] pkt_r;
  logic             pkt_valid_r;
  logic [NR-1:0]    gnt_r;
  logic             busy_r;
  logic             err_r;
  logic [IDW-1:0]   grant_id_r;
  logic [IDW-1:0]   rr_r;
  logic [CW-1:0]    cnt_r;

  logic [NR-1:0]    win_onehot_s;
  logic [IDW-1:0]   win_idx_s;
  logic             any_s;
  logic [TS*DW-1:0] payload_s;
  logic [DW-1:0]    word0_s;
  logic             timeout_s;

  rr_arbiter #(
    .NR  (NR),
    .IDW (IDW)
  ) u_rr (
    .req        (req),
    .pointer    (rr_r),
    .winner     (win_onehot_s),
    .winner_idx (win_idx_s),
    .any        (any_s)
  );

  // AND-OR mux of the winning requester's cacheline using the one-hot grant.
  always_comb begin
    payload_s = '0;
    for (int r = 0; r < NR; r++) begin
      payload_s = payload_s | (req_data[r*TS*DW +: TS*DW] & {(TS*DW){win_onehot_s[r]}});
    end
  end

  // Header word for the next launch: inverted toggle plus the winner id.
  always_comb begin
    word0_s                 = '0;
    word0_s[TOGGLE_BIT]     = ~pkt_r[TOGGLE_BIT];
    word0_s[ID_LSB +: IDW]  = win_idx_s;
  end

  assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));

  // Arbitration FSM: launch in IDLE, hold the packet in SEND until ack or timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      pkt_r       <= {{(FS*DW-1){1'b0}}, 1'b1};
      pkt_valid_r <= 1'b0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      grant_id_r  <= '0;
      rr_r        <= IDW'(NR - 1);
      cnt_r       <= '0;
    end else begin
      gnt_r <= '0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (any_s) begin
            pkt_r       <= {payload_s, word0_s};
            grant_id_r  <= win_idx_s;
            pkt_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= SEND;
          end
        end
        SEND: begin
          if (pkt_ack) begin
            // Ack takes precedence over a coincident timeout.
            gnt_r       <= {{(NR-1){1'b0}}, 1'b1} << grant_id_r;
            pkt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            rr_r        <= grant_id_r;
            cnt_r       <= '0;
            state_r     <= IDLE;
          end else if (timeout_s) begin
            // Pointer left alone so the same requester is retried first.
            err_r       <= 1'b1;
            pkt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= '0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          pkt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign PKT       = pkt_r;
  assign pkt_valid = pkt_valid_r;
  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_list_fetch_arbiter.sv
// Directed self-checking bench for list_fetch_arbiter (NR=4, FS=8, TIMEOUT=8).
module tb_list_fetch_arbiter;

  localparam int DW      = 32;
  localparam int FS      = 8;
  localparam int TS      = FS - 1;
  localparam int NR      = 4;
  localparam int TIMEOUT = 8;

  logic                    CLK;
  logic                    RESET;
  logic [NR-1:0]           req;
  logic [NR*TS*DW-1:0]     req_data;
  logic [NR-1:0]           gnt;
  logic [FS*DW-1:0]        PKT;
  logic                    pkt_valid;
  logic                    pkt_ack;
  logic                    busy;
  logic                    err;
  logic [1:0]              grant_id;

  int checks;
  int failures;

  list_fetch_arbiter #(
    .DW (DW), .FS (FS), .NR (NR), .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK (CLK), .RESET (RESET), .req (req), .req_data (req_data),
    .gnt (gnt), .PKT (PKT), .pkt_valid (pkt_valid), .pkt_ack (pkt_ack),
    .busy (busy), .err (err), .grant_id (grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] pkt_word(input int k);
    return PKT[k*DW +: DW];
  endfunction

  // Requester r, payload word j (0-based) = (r << 8) | (j + 1).
  task automatic load_default_data();
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < TS; j++)
        req_data[(r*TS + j)*DW +: DW] = (r << 8) | (j + 1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    req     = 4'b0000;
    pkt_ack = 1'b0;
    load_default_data();
    RESET   = 1'b1;
    step();
    RESET   = 1'b0;
  endtask

  task automatic test_reset();
    req     = 4'b0000;
    pkt_ack = 1'b0;
    load_default_data();
    RESET   = 1'b1;
    #3;
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || gnt !== 4'b0000 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b busy=%b err=%b gnt=%b id=%0d, required 0 0 0 0000 0", pkt_valid, busy, err, gnt, grant_id);
    end
    checks++;
    if (PKT !== {{(FS*DW-1){1'b0}}, 1'b1}) begin
      failures++;
      $display("FAIL reset_pkt: got %h required word0=1 rest 0", PKT);
    end
    step();
    RESET = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_valid: valid=%b busy=%b required 1 1", pkt_valid, busy);
    end
    checks++;
    if (pkt_word(0) !== 32'h0 || pkt_word(7) !== 32'h7 || pkt_word(1) !== 32'h1) begin
      failures++;
      $display("FAIL single_pkt: w0=%h w1=%h w7=%h required 0 1 7", pkt_word(0), pkt_word(1), pkt_word(7));
    end
    step();
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    req     = 4'b0000;
    checks++;
    if (gnt !== 4'b0001 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt: gnt=%b valid=%b required 0001 0", gnt, pkt_valid);
    end
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_gnt_width: gnt=%b required 0000", gnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id [5];
    logic       exp_tg [5];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_tg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (pkt_valid !== 1'b1 || grant_id !== exp_id[n] || gnt !== 4'b0000 ||
          pkt_word(0) !== {29'd0, exp_id[n], exp_tg[n]} ||
          pkt_word(1) !== ({24'd0, 6'd0, exp_id[n]} << 8 | 32'd1)) begin
        failures++;
        $display("FAIL rr_launch%0d: valid=%b id=%0d gnt=%b w0=%h w1=%h required id=%0d toggle=%b",
                 n, pkt_valid, grant_id, gnt, pkt_word(0), pkt_word(1), exp_id[n], exp_tg[n]);
      end
      pkt_ack = 1'b1;
      step();
      pkt_ack = 1'b0;
      checks++;
      if (gnt !== (4'b0001 << exp_id[n]) || pkt_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_gnt%0d: gnt=%b valid=%b required %b 0", n, gnt, pkt_valid, 4'b0001 << exp_id[n]);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    int  cycles;
    logic saw_gnt;
    apply_reset();
    req = 4'b0100;
    step();
    cycles  = 0;
    saw_gnt = 1'b0;
    while (pkt_valid === 1'b1 && cycles < 20) begin
      cycles++;
      if (gnt !== 4'b0000) saw_gnt = 1'b1;
      step();
    end
    checks++;
    if (cycles != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_len: valid high %0d cycles required %0d", cycles, TIMEOUT);
    end
    checks++;
    if (err !== 1'b1 || gnt !== 4'b0000 || saw_gnt !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: err=%b gnt=%b saw_gnt=%b required 1 0000 0", err, gnt, saw_gnt);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b1 || grant_id !== 2'd2 || pkt_word(0) !== 32'h5 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_relaunch: valid=%b id=%0d w0=%h err=%b required 1 2 5 1", pkt_valid, grant_id, pkt_word(0), err);
    end
    req     = 4'b0000;
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    step();
  endtask

  task automatic test_ack_at_timeout();
    apply_reset();
    req = 4'b0010;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL edge_valid: valid=%b required 1 on last SEND cycle", pkt_valid);
    end
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    req     = 4'b0000;
    checks++;
    if (gnt !== 4'b0010 || err !== 1'b0 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL edge_ack: gnt=%b err=%b valid=%b required 0010 0 0", gnt, err, pkt_valid);
    end
    step();
  endtask

  task automatic test_hold_stable();
    apply_reset();
    req = 4'b0001;
    step();
    req = 4'b0000;
    for (int j = 0; j < TS; j++) req_data[j*DW +: DW] = 32'hFFFF_FFFF;
    step();
    step();
    checks++;
    if (pkt_valid !== 1'b1 || pkt_word(1) !== 32'h1 || pkt_word(7) !== 32'h7) begin
      failures++;
      $display("FAIL hold_pkt: valid=%b w1=%h w7=%h required 1 1 7", pkt_valid, pkt_word(1), pkt_word(7));
    end
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL hold_gnt: gnt=%b required 0001", gnt);
    end
    load_default_data();
    step();
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    req = 4'b1000;
    step();
    checks++;
    if (pkt_valid !== 1'b1 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL mid_launch: valid=%b id=%0d required 1 3", pkt_valid, grant_id);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000 || grant_id !== 2'd0 ||
        PKT !== {{(FS*DW-1){1'b0}}, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset: valid=%b busy=%b gnt=%b id=%0d w0=%h required 0 0 0000 0 1",
               pkt_valid, busy, gnt, grant_id, pkt_word(0));
    end
    step();
    RESET = 1'b0;
    req   = 4'b1001;
    step();
    checks++;
    if (grant_id !== 2'd0 || pkt_valid !== 1'b1 || pkt_word(0) !== 32'h0) begin
      failures++;
      $display("FAIL mid_regrant: id=%0d valid=%b w0=%h required 0 1 0", grant_id, pkt_valid, pkt_word(0));
    end
    req     = 4'b0000;
    pkt_ack = 1'b1;
    step();
    pkt_ack = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    req      = 4'b0000;
    pkt_ack  = 1'b0;
    req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_hold_stable();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
